// File: rtl/vdp_cpu_port_pkg.sv
// Shared definitions for the VDP CPU access port: FSM states, port selects,
// pointer width and control-byte flag positions.
package vdp_cpu_port_pkg;

    localparam int unsigned PTR_W = 14;

    localparam logic RS_DATA = 1'b0;
    localparam logic RS_CTRL = 1'b1;

    localparam int unsigned REG_FLAG   = 7;
    localparam int unsigned WRITE_FLAG = 6;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRdWait
    } state_e;

    typedef enum logic {
        OpRead,
        OpWrite
    } op_kind_e;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p + PTR_W'(1);
    endfunction

endpackage

// File: rtl/vdp_cpu_port.sv
// CPU-side VDP access port: decodes data/control port strobes into VRAM cycles
// (one pending-op slot, read-ahead buffer) and VDP register write pulses.
module vdp_cpu_port
    import vdp_cpu_port_pkg::*;
#(
    parameter int unsigned A = 14,
    parameter int unsigned D = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cpu_cs,
    input  logic         cpu_rw,
    input  logic         cpu_rs,
    input  logic [7:0]   cpu_din,
    output logic [7:0]   cpu_dout,
    input  logic [5:0]   status_in,
    output logic         vram_req,
    input  logic         vram_grant,
    output logic [A-1:0] vram_addr,
    output logic [D-1:0] vram_din,
    output logic         vram_we,
    input  logic [D-1:0] vram_dout,
    output logic         reg_we,
    output logic [2:0]   reg_num,
    output logic [7:0]   reg_val,
    output logic         busy
);

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               toggle_q, toggle_d;
    logic [7:0]         low_q, low_d;
    logic               overrun_q, overrun_d;
    logic [7:0]         readbuf_q, readbuf_d;
    logic [7:0]         dout_q, dout_d;
    logic               reg_we_q, reg_we_d;
    logic [2:0]         reg_num_q, reg_num_d;
    logic [7:0]         reg_val_q, reg_val_d;
    logic [PTR_W-1:0]   op_addr_q, op_addr_d;
    logic [D-1:0]       op_data_q, op_data_d;
    op_kind_e           op_kind_q, op_kind_d;

    logic               queue;
    logic               accept;
    op_kind_e           queue_kind;
    logic [PTR_W-1:0]   queue_addr;

    assign busy = (state_q != StIdle);

    // Strobe decode and register-level side effects.
    always_comb begin
        ptr_d      = ptr_q;
        toggle_d   = toggle_q;
        low_d      = low_q;
        overrun_d  = overrun_q;
        dout_d     = dout_q;
        reg_we_d   = 1'b0;
        reg_num_d  = reg_num_q;
        reg_val_d  = reg_val_q;
        op_addr_d  = op_addr_q;
        op_data_d  = op_data_q;
        op_kind_d  = op_kind_q;
        queue      = 1'b0;
        queue_kind = OpRead;
        queue_addr = ptr_q;
        accept     = 1'b0;

        if (cpu_cs) begin
            if (cpu_rs == RS_CTRL) begin
                if (cpu_rw) begin
                    dout_d    = {busy, overrun_q, status_in};
                    toggle_d  = 1'b0;
                    overrun_d = 1'b0;
                end else if (!toggle_q) begin
                    low_d    = cpu_din;
                    toggle_d = 1'b1;
                end else begin
                    toggle_d = 1'b0;
                    if (cpu_din[REG_FLAG]) begin
                        reg_we_d  = 1'b1;
                        reg_num_d = cpu_din[2:0];
                        reg_val_d = low_q;
                    end else begin
                        // Pointer moves even if the prefetch below gets dropped.
                        ptr_d      = {cpu_din[5:0], low_q};
                        queue_addr = {cpu_din[5:0], low_q};
                        queue      = !cpu_din[WRITE_FLAG];
                    end
                end
            end else begin
                toggle_d   = 1'b0;
                queue      = 1'b1;
                queue_kind = cpu_rw ? OpRead : OpWrite;
                if (cpu_rw) begin
                    dout_d = readbuf_q;
                end
            end
        end

        if (queue) begin
            if (busy) begin
                overrun_d = 1'b1;
            end else begin
                accept    = 1'b1;
                op_addr_d = queue_addr;
                op_data_d = D'(cpu_din);
                op_kind_d = queue_kind;
                ptr_d     = ptr_inc(queue_addr);
            end
        end
    end

    // VRAM cycle sequencing.
    always_comb begin
        state_d   = state_q;
        vram_req  = 1'b0;
        vram_we   = 1'b0;
        readbuf_d = readbuf_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                vram_req = 1'b1;
                if (vram_grant) begin
                    if (op_kind_q == OpWrite) begin
                        vram_we = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StRdWait;
                    end
                end
            end
            StRdWait: begin
                readbuf_d = 8'(vram_dout);
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            toggle_q  <= 1'b0;
            low_q     <= '0;
            overrun_q <= 1'b0;
            readbuf_q <= '0;
            dout_q    <= '0;
            reg_we_q  <= 1'b0;
            reg_num_q <= '0;
            reg_val_q <= '0;
            op_addr_q <= '0;
            op_data_q <= '0;
            op_kind_q <= OpRead;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            toggle_q  <= toggle_d;
            low_q     <= low_d;
            overrun_q <= overrun_d;
            readbuf_q <= readbuf_d;
            dout_q    <= dout_d;
            reg_we_q  <= reg_we_d;
            reg_num_q <= reg_num_d;
            reg_val_q <= reg_val_d;
            op_addr_q <= op_addr_d;
            op_data_q <= op_data_d;
            op_kind_q <= op_kind_d;
        end
    end

    assign cpu_dout  = dout_q;
    assign reg_we    = reg_we_q;
    assign reg_num   = reg_num_q;
    assign reg_val   = reg_val_q;
    assign vram_addr = op_addr_q[A-1:0];
    assign vram_din  = op_data_q;

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Bench for vdp_cpu_port: vector table, hand-written stall/overrun/reset
// sequences, and a randomized run against a transaction-level model.
module tb_vdp_cpu_port;

    localparam logic CTRL = 1'b1;
    localparam logic DATA = 1'b0;
    localparam logic RD   = 1'b1;
    localparam logic WR   = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_cs = 1'b0;
    logic        cpu_rw = 1'b0;
    logic        cpu_rs = 1'b0;
    logic [7:0]  cpu_din = 8'h00;
    logic [7:0]  cpu_dout;
    logic [5:0]  status_in = 6'h2A;
    logic        vram_req;
    logic        vram_grant;
    logic [13:0] vram_addr;
    logic [7:0]  vram_din;
    logic        vram_we;
    logic [7:0]  vram_dout = 8'h00;
    logic        reg_we;
    logic [2:0]  reg_num;
    logic [7:0]  reg_val;
    logic        busy;

    logic        grant_man = 1'b1;
    logic        rand_mode = 1'b0;
    logic        rnd_grant = 1'b1;
    logic        pre_we = 1'b0;
    logic [13:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;
    int          we_count = 0;
    int          total = 0;
    int          bad = 0;

    logic [7:0]  vram [16384] = '{default: 8'h00};

    always #5 clk = ~clk;

    assign vram_grant = rand_mode ? rnd_grant : grant_man;

    always @(negedge clk) rnd_grant = 1'($urandom_range(0, 1));

    // Synchronous single-port RAM: read data one cycle after the address.
    always @(posedge clk) begin
        if (pre_we) vram[pre_addr] <= pre_data;
        else if (vram_we) vram[vram_addr] <= vram_din;
        vram_dout <= vram[vram_addr];
        if (vram_we) we_count = we_count + 1;
    end

    vdp_cpu_port #(.A(14), .D(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_cs     (cpu_cs),
        .cpu_rw     (cpu_rw),
        .cpu_rs     (cpu_rs),
        .cpu_din    (cpu_din),
        .cpu_dout   (cpu_dout),
        .status_in  (status_in),
        .vram_req   (vram_req),
        .vram_grant (vram_grant),
        .vram_addr  (vram_addr),
        .vram_din   (vram_din),
        .vram_we    (vram_we),
        .vram_dout  (vram_dout),
        .reg_we     (reg_we),
        .reg_num    (reg_num),
        .reg_val    (reg_val),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [13:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Returns at the negedge after the sampling edge (cycle N+1).
    task automatic access(input logic rs, input logic rw, input logic [7:0] din);
        @(negedge clk);
        cpu_cs  = 1'b1;
        cpu_rs  = rs;
        cpu_rw  = rw;
        cpu_din = din;
        @(negedge clk);
        cpu_cs  = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n = n + 1;
            @(negedge clk);
        end
        check("busy_clears", busy, 0);
    endtask

    typedef struct {
        logic       rs;
        logic       rw;
        logic [7:0] din;
        logic [7:0] exp_dout;
        int         exp_busy;
        logic       exp_reg_we;
        logic [2:0] exp_num;
        logic [7:0] exp_val;
    } vec_t;

    vec_t vecs[15];

    logic [7:0]  m_mem [16384];
    logic [13:0] m_ptr;
    logic        m_tog;
    logic [7:0]  m_low;
    logic [7:0]  m_rb;

    initial begin
        int n;
        int stall_bad;
        int we_before;
        int first_bad;

        vecs[0]  = '{CTRL, WR, 8'h34, 8'h00, 0, 1'b0, 3'd0, 8'h00};
        vecs[1]  = '{CTRL, WR, 8'h12, 8'h00, 2, 1'b0, 3'd0, 8'h00};
        vecs[2]  = '{DATA, RD, 8'h00, 8'h11, 2, 1'b0, 3'd0, 8'h00};
        vecs[3]  = '{DATA, RD, 8'h00, 8'h22, 2, 1'b0, 3'd0, 8'h00};
        vecs[4]  = '{CTRL, RD, 8'h00, 8'h2A, 0, 1'b0, 3'd0, 8'h00};
        vecs[5]  = '{CTRL, WR, 8'h34, 8'h00, 0, 1'b0, 3'd0, 8'h00};
        vecs[6]  = '{CTRL, WR, 8'h52, 8'h00, 0, 1'b0, 3'd0, 8'h00};
        vecs[7]  = '{DATA, WR, 8'hAA, 8'h00, 1, 1'b0, 3'd0, 8'h00};
        vecs[8]  = '{DATA, WR, 8'hBB, 8'h00, 1, 1'b0, 3'd0, 8'h00};
        vecs[9]  = '{CTRL, WR, 8'h07, 8'h00, 0, 1'b0, 3'd0, 8'h00};
        vecs[10] = '{CTRL, WR, 8'h85, 8'h00, 0, 1'b1, 3'd5, 8'h07};
        vecs[11] = '{CTRL, WR, 8'hFF, 8'h00, 0, 1'b0, 3'd0, 8'h00};
        vecs[12] = '{CTRL, WR, 8'h7F, 8'h00, 0, 1'b0, 3'd0, 8'h00};
        vecs[13] = '{DATA, WR, 8'h5A, 8'h00, 1, 1'b0, 3'd0, 8'h00};
        vecs[14] = '{DATA, WR, 8'hC3, 8'h00, 1, 1'b0, 3'd0, 8'h00};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst cpu_dout", cpu_dout, 0);
        check("rst vram_req", vram_req, 0);
        check("rst vram_we", vram_we, 0);
        check("rst vram_addr", vram_addr, 0);
        check("rst vram_din", vram_din, 0);
        check("rst reg_we", reg_we, 0);
        check("rst reg_num", reg_num, 0);
        check("rst reg_val", reg_val, 0);
        check("rst busy", busy, 0);
        rst_n = 1'b1;

        poke(14'h1234, 8'h11);
        poke(14'h1235, 8'h22);

        for (int i = 0; i < 15; i++) begin
            access(vecs[i].rs, vecs[i].rw, vecs[i].din);
            if (vecs[i].rw) check($sformatf("vec%0d dout", i), cpu_dout, vecs[i].exp_dout);
            check($sformatf("vec%0d reg_we", i), reg_we, vecs[i].exp_reg_we);
            if (vecs[i].exp_reg_we) begin
                check($sformatf("vec%0d reg_num", i), reg_num, vecs[i].exp_num);
                check($sformatf("vec%0d reg_val", i), reg_val, vecs[i].exp_val);
            end
            check($sformatf("vec%0d vram_req", i), vram_req, vecs[i].exp_busy != 0);
            wait_idle(n);
            check($sformatf("vec%0d busy_cycles", i), n, vecs[i].exp_busy);
            if (vecs[i].exp_reg_we) begin
                @(negedge clk);
                check($sformatf("vec%0d reg_we_width", i), reg_we, 0);
            end
        end
        check("mem 1234", vram[14'h1234], 8'hAA);
        check("mem 1235", vram[14'h1235], 8'hBB);
        check("mem 3fff", vram[14'h3FFF], 8'h5A);
        check("mem 0000", vram[14'h0000], 8'hC3);

        // Stalled grant, overrun, sticky flag cleared by status read
        access(CTRL, WR, 8'h00);
        access(CTRL, WR, 8'h50);
        grant_man = 1'b0;
        access(DATA, WR, 8'h66);
        stall_bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (!(vram_req && !vram_we && busy)) stall_bad = stall_bad + 1;
            @(negedge clk);
        end
        check("stall held", stall_bad, 0);
        access(DATA, WR, 8'h77);
        access(CTRL, RD, 8'h00);
        check("status overrun", cpu_dout, 8'hEA);
        access(CTRL, RD, 8'h00);
        check("status cleared", cpu_dout, 8'hAA);
        grant_man = 1'b1;
        wait_idle(n);
        check("stall release cycles", n, 1);
        check("mem 1000", vram[14'h1000], 8'h66);
        check("mem 1001 untouched", vram[14'h1001], 8'h00);
        access(DATA, WR, 8'h88);
        wait_idle(n);
        check("mem 1001 after drop", vram[14'h1001], 8'h88);
        access(CTRL, RD, 8'h00);
        check("status idle", cpu_dout, 8'h2A);

        // Reset while a write waits for grant
        access(CTRL, WR, 8'h00);
        access(CTRL, WR, 8'h60);
        grant_man = 1'b0;
        access(DATA, WR, 8'h99);
        access(CTRL, WR, 8'h11);
        @(negedge clk);
        we_before = we_count;
        rst_n = 1'b0;
        #1;
        check("midrst outs", {cpu_dout, vram_req, vram_we, vram_addr, reg_we, busy}, 0);
        check("midrst vram_din", vram_din, 0);
        check("midrst reg", {reg_num, reg_val}, 0);
        grant_man = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst no we", we_count - we_before, 0);
        check("midrst mem 2000", vram[14'h2000], 8'h00);
        check("midrst busy", busy, 0);
        access(CTRL, WR, 8'h3C);
        access(CTRL, WR, 8'h83);
        check("midrst toggle reg_we", reg_we, 1);
        check("midrst toggle reg", {reg_num, reg_val}, {3'd3, 8'h3C});

        // Randomized run against a transaction-level model
        for (int k = 0; k < 16384; k++) m_mem[k] = vram[k];
        m_ptr = '0;
        m_tog = 1'b0;
        m_low = 8'h3C;
        m_rb  = 8'h00;
        rand_mode = 1'b1;
        for (int k = 0; k < 400; k++) begin
            int unsigned op;
            logic [7:0]  b;
            logic        e_we;
            logic [2:0]  e_num;
            logic [7:0]  e_val;
            op    = $urandom_range(0, 3);
            b     = 8'($urandom);
            e_we  = 1'b0;
            e_num = '0;
            e_val = '0;
            case (op)
                0: begin
                    if (!m_tog) begin
                        m_low = b;
                        m_tog = 1'b1;
                    end else begin
                        m_tog = 1'b0;
                        if (b[7]) begin
                            e_we  = 1'b1;
                            e_num = b[2:0];
                            e_val = m_low;
                        end else begin
                            m_ptr = {b[5:0], m_low};
                            if (!b[6]) begin
                                m_rb  = m_mem[m_ptr];
                                m_ptr = m_ptr + 14'd1;
                            end
                        end
                    end
                    access(CTRL, WR, b);
                    check($sformatf("rnd%0d reg_we", k), reg_we, e_we);
                    if (e_we) check($sformatf("rnd%0d reg", k), {reg_num, reg_val}, {e_num, e_val});
                end
                1: begin
                    m_mem[m_ptr] = b;
                    m_ptr = m_ptr + 14'd1;
                    m_tog = 1'b0;
                    access(DATA, WR, b);
                    check($sformatf("rnd%0d reg_we", k), reg_we, 0);
                end
                2: begin
                    access(DATA, RD, b);
                    check($sformatf("rnd%0d data read", k), cpu_dout, m_rb);
                    m_rb  = m_mem[m_ptr];
                    m_ptr = m_ptr + 14'd1;
                    m_tog = 1'b0;
                end
                default: begin
                    status_in = 6'($urandom);
                    access(CTRL, RD, b);
                    check($sformatf("rnd%0d status", k), cpu_dout, {2'b00, status_in});
                    m_tog = 1'b0;
                end
            endcase
            wait_idle(n);
        end
        rand_mode = 1'b0;
        first_bad = -1;
        for (int k = 0; k < 16384; k++) begin
            if (first_bad < 0 && vram[k] !== m_mem[k]) first_bad = k;
        end
        check("rnd mem image first bad addr", first_bad, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
